// File: rtl/vending_core_multi.sv
// Parameterised vending-machine control core: item selection, coin collection with a
// credit ceiling, per-item stock, change/refund reporting and an inactivity timeout.
module vending_core_multi #(
  parameter int unsigned                   NUM_ITEMS   = 4,
  parameter int unsigned                   CREDIT_W    = 9,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {9'd135, 9'd100, 9'd75, 9'd50},
  parameter int unsigned                   MAX_CREDIT  = 300,
  parameter int unsigned                   STOCK_W     = 4,
  parameter int unsigned                   STOCK_INIT  = 5,
  parameter int unsigned                   TIMEOUT_CYC = 1_000_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_ITEMS)-1:0] item_sel,
  input  logic                         coin_50,
  input  logic                         coin_25,
  input  logic                         coin_10,
  input  logic                         confirm,
  input  logic                         cancel,
  input  logic                         restock,
  output logic [1:0]                   state,
  output logic [CREDIT_W-1:0]          credit,
  output logic [CREDIT_W-1:0]          price,
  output logic [CREDIT_W-1:0]          change,
  output logic [CREDIT_W-1:0]          refund,
  output logic                         vend,
  output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
  output logic                         led_insuff,
  output logic                         sold_out,
  output logic                         coin_reject
);

  localparam int unsigned ITEM_W = $clog2(NUM_ITEMS);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_SELECT   = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2
  } state_t;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
    return PRICES[32'(idx)*CREDIT_W +: CREDIT_W];
  endfunction

  state_t              state_q, state_d;
  logic [ITEM_W-1:0]   active_q, active_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic [TO_W-1:0]     timer_q, timer_d;

  logic [CREDIT_W-1:0] credit_d, price_d, change_d, refund_d;
  logic                vend_d, led_d, sold_out_d, reject_d;
  logic [ITEM_W-1:0]   vend_item_d;

  logic                any_coin, multi_coin, any_evt, timeout;
  logic [CREDIT_W-1:0] coin_val, price_cur;
  logic [CREDIT_W:0]   coin_sum;

  // Coin decode: only the highest denomination in a cycle is ever considered.
  assign any_coin   = coin_50 | coin_25 | coin_10;
  assign multi_coin = (coin_50 & coin_25) | (coin_50 & coin_10) | (coin_25 & coin_10);
  assign coin_val   = coin_50 ? CREDIT_W'(50) :
                      coin_25 ? CREDIT_W'(25) :
                      coin_10 ? CREDIT_W'(10) : CREDIT_W'(0);
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_val};
  assign price_cur  = price_of(active_q);

  assign any_evt = any_coin | confirm | cancel;
  assign timeout = (state_q != ST_SELECT) && !any_evt &&
                   (timer_q == TO_W'(TIMEOUT_CYC - 1));

  assign state = state_q;

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    stock_d     = stock_q;
    timer_d     = '0;
    credit_d    = credit;
    change_d    = change;
    refund_d    = refund;
    vend_d      = 1'b0;
    vend_item_d = vend_item;
    led_d       = led_insuff;
    reject_d    = 1'b0;

    case (state_q)
      ST_SELECT: begin
        active_d = item_sel;
        if (any_coin) begin
          if (stock_q[item_sel] == '0) begin
            reject_d = 1'b1;
          end else begin
            reject_d = multi_coin;
            credit_d = coin_val;
            refund_d = '0;
            state_d  = ST_COLLECT;
          end
        end
        if (restock) begin
          for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = STOCK_W'(STOCK_INIT);
          end
        end
      end

      ST_COLLECT: begin
        if (cancel || timeout) begin
          reject_d = any_coin;
          refund_d = credit;
          credit_d = '0;
          led_d    = 1'b0;
          state_d  = ST_SELECT;
        end else if (confirm) begin
          reject_d = any_coin;
          if (credit < price_cur) begin
            led_d = 1'b1;
          end else begin
            vend_d      = 1'b1;
            vend_item_d = active_q;
            change_d    = credit - price_cur;
            credit_d    = '0;
            led_d       = 1'b0;
            state_d     = ST_DISPENSE;
            if (stock_q[active_q] != '0) begin
              stock_d[active_q] = stock_q[active_q] - STOCK_W'(1);
            end
          end
        end else if (any_coin) begin
          if (coin_sum > (CREDIT_W+1)'(MAX_CREDIT)) begin
            reject_d = 1'b1;
          end else begin
            reject_d = multi_coin;
            credit_d = coin_sum[CREDIT_W-1:0];
            led_d    = 1'b0;
          end
        end
      end

      ST_DISPENSE: begin
        reject_d = any_coin;
        if (confirm || timeout) begin
          change_d = '0;
          state_d  = ST_SELECT;
        end
      end

      default: begin
        state_d = ST_SELECT;
      end
    endcase

    // The timer only runs while a transaction sits untouched in one state.
    if ((state_q != ST_SELECT) && (state_d == state_q) && !any_evt) begin
      timer_d = timer_q + TO_W'(1);
    end

    if (state_d == ST_SELECT) begin
      active_d = item_sel;
    end

    price_d    = price_of(active_d);
    sold_out_d = (stock_d[active_d] == '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SELECT;
      active_q    <= '0;
      timer_q     <= '0;
      credit      <= '0;
      price       <= price_of('0);
      change      <= '0;
      refund      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      led_insuff  <= 1'b0;
      sold_out    <= 1'b0;
      coin_reject <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      timer_q     <= timer_d;
      credit      <= credit_d;
      price       <= price_d;
      change      <= change_d;
      refund      <= refund_d;
      vend        <= vend_d;
      vend_item   <= vend_item_d;
      led_insuff  <= led_d;
      sold_out    <= sold_out_d;
      coin_reject <= reject_d;
      stock_q     <= stock_d;
    end
  end

endmodule

// File: tb/tb_vending_core_multi.sv
// Scoreboard bench for vending_core_multi: a transaction-level reference model predicts
// every cycle's outputs; a monitor pops and compares after each clock edge.
module tb_vending_core_multi;

  localparam int STOCK_INIT = 2;
  localparam int TMO        = 16;
  localparam int MAXC       = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] item_sel = '0;
  logic       coin_50 = 1'b0, coin_25 = 1'b0, coin_10 = 1'b0;
  logic       confirm = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic [1:0] state;
  logic [8:0] credit, price, change, refund;
  logic       vend;
  logic [1:0] vend_item;
  logic       led_insuff, sold_out, coin_reject;

  vending_core_multi #(
    .STOCK_INIT (STOCK_INIT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .item_sel   (item_sel),
    .coin_50    (coin_50),
    .coin_25    (coin_25),
    .coin_10    (coin_10),
    .confirm    (confirm),
    .cancel     (cancel),
    .restock    (restock),
    .state      (state),
    .credit     (credit),
    .price      (price),
    .change     (change),
    .refund     (refund),
    .vend       (vend),
    .vend_item  (vend_item),
    .led_insuff (led_insuff),
    .sold_out   (sold_out),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, credit, price, change, refund, vitem;
    bit vend, chk_vi, led, sold, rej;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: transaction state kept as plain integers.
  int prices[4] = '{50, 75, 100, 135};
  int m_stock[4];
  int m_state, m_credit, m_change, m_refund, m_item, m_vi, m_idle;
  bit m_led;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, input int sel, input bit c50, input bit c25,
                            input bit c10, input bit cf, input bit cn, input bit rs);
    exp_t e;
    int   ncoin, best, prev;
    bit   evt, tmo, rej, vnd;
    ncoin = int'(c50) + int'(c25) + int'(c10);
    best  = c50 ? 50 : (c25 ? 25 : (c10 ? 10 : 0));
    rej   = 1'b0;
    vnd   = 1'b0;
    prev  = m_state;
    if (r) begin
      m_state = 0; m_credit = 0; m_change = 0; m_refund = 0;
      m_led = 1'b0; m_item = 0; m_vi = 0; m_idle = 0;
      foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
      e.chk_vi = 1'b1;
    end else begin
      evt = (ncoin > 0) || cf || cn;
      if (m_state != 0 && !evt) m_idle++;
      else m_idle = 0;
      tmo = (m_idle >= TMO);
      if (m_state == 0) begin
        if (ncoin > 0) begin
          if (m_stock[sel] == 0) rej = 1'b1;
          else begin
            rej = (ncoin > 1); m_item = sel; m_credit = best; m_refund = 0; m_state = 1;
          end
        end
        if (rs) foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
      end else if (m_state == 1) begin
        if (cn || tmo) begin
          rej = (ncoin > 0); m_refund = m_credit; m_credit = 0; m_led = 1'b0; m_state = 0;
        end else if (cf) begin
          rej = (ncoin > 0);
          if (m_credit < prices[m_item]) m_led = 1'b1;
          else begin
            vnd = 1'b1; m_vi = m_item; m_change = m_credit - prices[m_item];
            m_credit = 0; m_led = 1'b0; m_state = 2;
            if (m_stock[m_item] > 0) m_stock[m_item]--;
          end
        end else if (ncoin > 0) begin
          if (m_credit + best > MAXC) rej = 1'b1;
          else begin
            m_credit += best; m_led = 1'b0; rej = (ncoin > 1);
          end
        end
      end else begin
        rej = (ncoin > 0);
        if (cf || tmo) begin
          m_change = 0; m_state = 0;
        end
      end
      if (m_state != prev) m_idle = 0;
      if (m_state == 0 || prev == 0) m_item = sel;
      e.chk_vi = vnd;
    end
    e.st = m_state; e.credit = m_credit; e.price = prices[m_item];
    e.change = m_change; e.refund = m_refund; e.vend = vnd; e.vitem = m_vi;
    e.led = m_led; e.sold = (m_stock[m_item] == 0); e.rej = rej;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive at the falling edge and record the prediction.
  task automatic cyc(input bit r, input int sel, input bit c50, input bit c25, input bit c10,
                     input bit cf, input bit cn, input bit rs);
    @(negedge clk);
    rst = r; item_sel = 2'(sel);
    coin_50 = c50; coin_25 = c25; coin_10 = c10;
    confirm = cf; cancel = cn; restock = rs;
    model_step(r, sel, c50, c25, c10, cf, cn, rs);
  endtask

  task automatic coin(input int sel, input int v);
    cyc(1'b0, sel, v == 50, v == 25, v == 10, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic conf(input int sel);
    cyc(1'b0, sel, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic canc(input int sel);
    cyc(1'b0, sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every clock edge presents a full output set; compare against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state", 32'(state), mon_e.st);
      chk("credit", 32'(credit), mon_e.credit);
      chk("price", 32'(price), mon_e.price);
      chk("change", 32'(change), mon_e.change);
      chk("refund", 32'(refund), mon_e.refund);
      chk("vend", 32'(vend), int'(mon_e.vend));
      chk("led_insuff", 32'(led_insuff), int'(mon_e.led));
      chk("sold_out", 32'(sold_out), int'(mon_e.sold));
      chk("coin_reject", 32'(coin_reject), int'(mon_e.rej));
      if (mon_e.chk_vi) chk("vend_item", 32'(vend_item), mon_e.vitem);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Insufficient credit, then a vend with exact change.
    coin(0, 25); conf(0); coin(0, 25); conf(0); idle(0, 1); conf(0); idle(0, 1);

    // Change, then the credit ceiling.
    coin(3, 50); coin(3, 50); coin(3, 50); conf(3); conf(3);
    for (int i = 0; i < 7; i++) coin(3, 50);
    canc(3);

    // Cancel with refund.
    coin(1, 50); canc(1); idle(1, 2);

    // Sell out item 2, refused coin, restock.
    for (int k = 0; k < 2; k++) begin
      coin(2, 50); coin(2, 50); conf(2); conf(2);
    end
    idle(2, 1); coin(2, 10); idle(2, 1);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    coin(2, 10); canc(2);

    // Timeouts in COLLECT and DISPENSE.
    coin(0, 10); idle(0, 15); idle(0, 1); idle(0, 1);
    coin(0, 50); conf(0); idle(0, 15); idle(0, 1); idle(0, 1);

    // Simultaneous events and a mid-transaction reset.
    coin(2, 50); coin(2, 50);
    cyc(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    coin(0, 10);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    coin(1, 25);
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1);

    // Randomised traffic with occasional long idle runs around the timeout boundary.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        idle(int'($urandom_range(0, 3)), int'($urandom_range(14, 18)));
      end else begin
        cyc($urandom_range(0, 399) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0);
      end
    end

    @(negedge clk);
    rst = 1'b0; coin_50 = 1'b0; coin_25 = 1'b0; coin_10 = 1'b0;
    confirm = 1'b0; cancel = 1'b0; restock = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
